// File: rtl/pci_master_pkg.sv
// Shared PCI initiator constants, state encoding and request decode helper.
package pci_master_pkg;

   localparam int unsigned AD_W     = 32;
   localparam int unsigned CBE_W    = 4;

   localparam logic [CBE_W-1:0] CMD_READ  = 4'b0110;
   localparam logic [CBE_W-1:0] CMD_WRITE = 4'b0111;
   localparam logic [CBE_W-1:0] CBE_IDLE  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_SWAIT,
      ST_TURN
   } state_e;

   // Only memory read and memory write are supported commands
   function automatic logic cmd_supported(input logic [CBE_W-1:0] c);
      return (c == CMD_READ) || (c == CMD_WRITE);
   endfunction

endpackage

// File: rtl/pci_wfifo.sv
// Write-data staging FIFO: DEPTH x 32, registered count/full/empty, flush support.
module pci_wfifo
   import pci_master_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [AD_W-1:0]           wdata,
   input  logic                      pop,
   input  logic                      flush,
   output logic [AD_W-1:0]           head,
   output logic [AD_W-1:0]           head_next,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AD_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;
   logic [CNT_W-1:0] cnt_nxt_c;

   assign do_push_c = push && !full;
   assign do_pop_c  = pop && !empty;
   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_ptr + PTR_W'(1)];

   // Occupancy after this clock; a flush keeps only a word pushed in the same clock
   always_comb begin
      cnt_nxt_c = count;
      if (flush) begin
         cnt_nxt_c = CNT_W'(do_push_c);
      end else begin
         cnt_nxt_c = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

   // Pointer and status registers; pointers wrap naturally modulo DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else if (do_pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= cnt_nxt_c;
         full  <= (cnt_nxt_c == CNT_W'(DEPTH));
         empty <= (cnt_nxt_c == '0);
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/pci_master.sv
// PCI initiator: launches single/burst memory reads and writes from a local request port.
module pci_master
   import pci_master_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned LEN_W      = 4,
   parameter int unsigned DEVSEL_TMO = 4
) (
   input  logic              CLK,
   input  logic              reset,
   output logic              FRAME,
   output logic              IRDY,
   output logic [3:0]        CBE,
   inout  wire  [31:0]       AD,
   input  logic              DEVSEL,
   input  logic              TRDY,
   input  logic              STOP,
   input  logic              req,
   input  logic [3:0]        cmd,
   input  logic [31:0]       addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [3:0]        byte_en,
   input  logic              wdata_wr,
   input  logic [31:0]       wdata,
   output logic              wfifo_full,
   output logic              busy,
   output logic              req_err,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic [LEN_W-1:0]  xfer_cnt,
   output logic              master_abort,
   output logic              target_stop
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned TMO_W = $clog2(DEVSEL_TMO + 1);

   state_e            state;
   logic              is_write;
   logic [LEN_W-1:0]  len_q;
   logic [AD_W-1:0]   ad_out;
   logic              ad_oe;
   logic              abort_pend;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              devsel_seen;

   logic [AD_W-1:0]   fifo_head;
   logic [AD_W-1:0]   fifo_head_next;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic              req_ok_c;
   logic              phase_done_c;
   logic              last_c;
   logic              stop_c;
   logic              tmo_hit_c;
   logic              fifo_pop_c;
   logic              fifo_flush_c;

   assign AD = ad_oe ? ad_out : 'z;

   assign req_ok_c     = cmd_supported(cmd) && (len != '0) &&
                         ((cmd != CMD_WRITE) || (32'(fifo_count) >= 32'(len)));
   assign phase_done_c = !IRDY && !TRDY && !DEVSEL;
   assign last_c       = ((xfer_cnt + LEN_W'(1)) == len_q);
   assign stop_c       = !STOP && !DEVSEL;
   assign tmo_hit_c    = !devsel_seen && DEVSEL && (tmo_cnt == TMO_W'(DEVSEL_TMO - 1));
   assign fifo_pop_c   = (state == ST_DATA) && is_write && phase_done_c && !fifo_empty;
   assign fifo_flush_c = (state == ST_TURN) && is_write;

   pci_wfifo #(.DEPTH(DEPTH)) u_wfifo (
      .clk       (CLK),
      .reset     (reset),
      .push      (wdata_wr),
      .wdata     (wdata),
      .pop       (fifo_pop_c),
      .flush     (fifo_flush_c),
      .head      (fifo_head),
      .head_next (fifo_head_next),
      .full      (wfifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // DEVSEL watchdog: counts clocks from the address phase until the target claims the cycle
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         tmo_cnt     <= '0;
         devsel_seen <= 1'b0;
      end else if (state == ST_IDLE) begin
         tmo_cnt     <= '0;
         devsel_seen <= 1'b0;
      end else if ((state == ST_ADDR) || (state == ST_DATA)) begin
         if (!DEVSEL) begin
            devsel_seen <= 1'b1;
         end else if (!devsel_seen) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
      end
   end

   // Transaction FSM with registered bus and status outputs
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         FRAME        <= 1'b1;
         IRDY         <= 1'b1;
         CBE          <= CBE_IDLE;
         ad_out       <= '0;
         ad_oe        <= 1'b0;
         is_write     <= 1'b0;
         len_q        <= '0;
         abort_pend   <= 1'b0;
         busy         <= 1'b0;
         req_err      <= 1'b0;
         rdata        <= '0;
         rdata_valid  <= 1'b0;
         done         <= 1'b0;
         xfer_cnt     <= '0;
         master_abort <= 1'b0;
         target_stop  <= 1'b0;
      end else begin
         done        <= 1'b0;
         rdata_valid <= 1'b0;
         req_err     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (req_ok_c) begin
                     is_write     <= (cmd == CMD_WRITE);
                     len_q        <= len;
                     xfer_cnt     <= '0;
                     master_abort <= 1'b0;
                     target_stop  <= 1'b0;
                     abort_pend   <= 1'b0;
                     FRAME        <= 1'b0;
                     ad_out       <= addr;
                     CBE          <= cmd;
                     ad_oe        <= 1'b1;
                     busy         <= 1'b1;
                     state        <= ST_ADDR;
                  end else begin
                     req_err <= 1'b1;
                  end
               end
            end
            ST_ADDR: begin
               IRDY <= 1'b0;
               CBE  <= byte_en;
               if (is_write) begin
                  ad_out <= fifo_head;
               end else begin
                  ad_oe <= 1'b0;
               end
               if (len_q == LEN_W'(1)) begin
                  FRAME <= 1'b1;
               end
               state <= ST_DATA;
            end
            ST_DATA: begin
               if (phase_done_c) begin
                  xfer_cnt <= xfer_cnt + LEN_W'(1);
                  if (is_write) begin
                     ad_out <= fifo_head_next;
                  end else begin
                     rdata       <= AD;
                     rdata_valid <= 1'b1;
                  end
               end
               if (phase_done_c && last_c) begin
                  FRAME <= 1'b1;
                  IRDY  <= 1'b1;
                  CBE   <= CBE_IDLE;
                  ad_oe <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_TURN;
               end else if (stop_c) begin
                  FRAME <= 1'b1;
                  state <= ST_SWAIT;
               end else if (phase_done_c) begin
                  // one phase left after this one: flag it as the final phase
                  if ((len_q - xfer_cnt) == LEN_W'(2)) begin
                     FRAME <= 1'b1;
                  end
               end else if (tmo_hit_c) begin
                  FRAME      <= 1'b1;
                  abort_pend <= 1'b1;
                  state      <= ST_SWAIT;
               end
            end
            ST_SWAIT: begin
               IRDY  <= 1'b1;
               CBE   <= CBE_IDLE;
               ad_oe <= 1'b0;
               done  <= 1'b1;
               if (abort_pend) begin
                  master_abort <= 1'b1;
               end else begin
                  target_stop <= 1'b1;
               end
               state <= ST_TURN;
            end
            ST_TURN: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pci_master.sv
// Directed bench for pci_master with a simple behavioural PCI target at 32'hA..32'hF.
module tb_pci_master;

   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             frame;
   logic             irdy;
   logic [3:0]       cbe;
   wire  [31:0]      ad_bus;
   logic             devsel;
   logic             trdy;
   logic             stop;
   logic             req;
   logic [3:0]       cmd;
   logic [31:0]      addr;
   logic [LEN_W-1:0] len;
   logic [3:0]       byte_en;
   logic             wdata_wr;
   logic [31:0]      wdata;
   logic             wfifo_full;
   logic             busy;
   logic             req_err;
   logic [31:0]      rdata;
   logic             rdata_valid;
   logic             done;
   logic [LEN_W-1:0] xfer_cnt;
   logic             master_abort;
   logic             target_stop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pci_master #(.DEPTH(8), .LEN_W(LEN_W), .DEVSEL_TMO(4)) dut (
      .CLK          (clk),
      .reset        (reset),
      .FRAME        (frame),
      .IRDY         (irdy),
      .CBE          (cbe),
      .AD           (ad_bus),
      .DEVSEL       (devsel),
      .TRDY         (trdy),
      .STOP         (stop),
      .req          (req),
      .cmd          (cmd),
      .addr         (addr),
      .len          (len),
      .byte_en      (byte_en),
      .wdata_wr     (wdata_wr),
      .wdata        (wdata),
      .wfifo_full   (wfifo_full),
      .busy         (busy),
      .req_err      (req_err),
      .rdata        (rdata),
      .rdata_valid  (rdata_valid),
      .done         (done),
      .xfer_cnt     (xfer_cnt),
      .master_abort (master_abort),
      .target_stop  (target_stop)
   );

   // Behavioural target: fast decode, zero wait states, optional disconnect after N phases
   logic [31:0] slv_mem [16];
   logic        sel;
   logic        slv_rd;
   logic        stopping;
   logic [3:0]  cur;
   int          nph;
   int          stop_after;
   logic        slv_we;

   assign slv_we = sel && !slv_rd && !stopping && !irdy && !trdy && !reset;
   assign ad_bus = (sel && slv_rd && !stopping) ? slv_mem[cur] : 'z;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         devsel   <= 1'b1;
         trdy     <= 1'b1;
         stop     <= 1'b1;
         sel      <= 1'b0;
         slv_rd   <= 1'b0;
         stopping <= 1'b0;
         cur      <= '0;
         nph      <= 0;
      end else if (!sel) begin
         if (!frame && irdy && (ad_bus[31:4] == 28'd0) && (ad_bus[3:0] >= 4'hA)) begin
            sel    <= 1'b1;
            cur    <= ad_bus[3:0];
            slv_rd <= (cbe == 4'b0110);
            devsel <= 1'b0;
            trdy   <= 1'b0;
            nph    <= 0;
         end
      end else if (stopping) begin
         if (frame) begin
            sel      <= 1'b0;
            stopping <= 1'b0;
            devsel   <= 1'b1;
            stop     <= 1'b1;
            trdy     <= 1'b1;
         end
      end else if (!irdy && !trdy) begin
         cur <= cur + 4'd1;
         nph <= nph + 1;
         if (frame) begin
            sel    <= 1'b0;
            devsel <= 1'b1;
            trdy   <= 1'b1;
         end else if ((stop_after != 0) && (nph + 1 == stop_after)) begin
            stop     <= 1'b0;
            trdy     <= 1'b1;
            stopping <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (slv_we) slv_mem[cur] <= ad_bus;
   end

   // Per-transaction observations
   int          cyc;
   logic        got_done;
   logic [31:0] rd_q [$];
   logic [7:0]  frame_pat;
   logic        fr_hist [64];
   logic        ir_hist [64];
   logic        saw_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      wdata_wr = 1'b1;
      wdata    = w;
      @(posedge clk); #1;
      wdata_wr = 1'b0;
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [LEN_W-1:0] l);
      cmd     = c;
      addr    = a;
      len     = l;
      byte_en = 4'hF;
      req     = 1'b1;
      @(posedge clk); #1;
      req     = 1'b0;
   endtask

   task automatic run_txn();
      cyc       = 0;
      got_done  = 1'b0;
      frame_pat = '0;
      rd_q.delete();
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(posedge clk); #1;
         cyc++;
         fr_hist[cyc] = frame;
         ir_hist[cyc] = irdy;
         if (rdata_valid) rd_q.push_back(rdata);
         if (!irdy) frame_pat = {frame_pat[6:0], frame};
         if (done) got_done = 1'b1;
      end
      chk("done_seen", 32'(got_done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req = 1'b0; cmd = '0; addr = '0; len = '0; byte_en = '0;
      wdata_wr = 1'b0; wdata = '0; stop_after = 0;
      repeat (3) @(posedge clk); #1;

      chk("rst_frame", 32'(frame), 32'd1);
      chk("rst_irdy", 32'(irdy), 32'd1);
      chk("rst_cbe", 32'(cbe), 32'hF);
      chk("rst_ad_oe", 32'(dut.ad_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_full", 32'(wfifo_full), 32'd0);
      chk("rst_xfer", 32'(xfer_cnt), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: three-phase burst write
      push_word(32'h11); push_word(32'h22); push_word(32'h33);
      issue(4'b0111, 32'hA, 4'd3);
      chk("t1_busy", 32'(busy), 32'd1);
      run_txn();
      chk("t1_cyc", 32'(cyc), 32'd4);
      chk("t1_xfer", 32'(xfer_cnt), 32'd3);
      chk("t1_abort", 32'(master_abort), 32'd0);
      chk("t1_tstop", 32'(target_stop), 32'd0);
      chk("t1_memA", slv_mem[4'hA], 32'h11);
      chk("t1_memB", slv_mem[4'hB], 32'h22);
      chk("t1_memC", slv_mem[4'hC], 32'h33);
      @(posedge clk); #1;
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // 2: three-phase burst read, FRAME released only in the final phase
      issue(4'b0110, 32'hA, 4'd3);
      run_txn();
      chk("t2_cyc", 32'(cyc), 32'd4);
      chk("t2_nvalid", 32'(rd_q.size()), 32'd3);
      chk("t2_rd0", rd_q[0], 32'h11);
      chk("t2_rd1", rd_q[1], 32'h22);
      chk("t2_rd2", rd_q[2], 32'h33);
      chk("t2_frame_pat", 32'(frame_pat), 32'h01);
      chk("t2_xfer", 32'(xfer_cnt), 32'd3);
      chk("t2_ad_oe", 32'(dut.ad_oe), 32'd0);
      chk("t2_cbe_turn", 32'(cbe), 32'hF);
      @(posedge clk); #1;

      // 3: no target at 0x20 -> master abort
      issue(4'b0110, 32'h20, 4'd2);
      run_txn();
      chk("t3_cyc", 32'(cyc), 32'd5);
      chk("t3_abort", 32'(master_abort), 32'd1);
      chk("t3_tstop", 32'(target_stop), 32'd0);
      chk("t3_xfer", 32'(xfer_cnt), 32'd0);
      chk("t3_nvalid", 32'(rd_q.size()), 32'd0);
      chk("t3_frame4", 32'(fr_hist[4]), 32'd1);
      chk("t3_irdy4", 32'(ir_hist[4]), 32'd0);
      @(posedge clk); #1;

      // 4: five-phase write disconnected by the target after phase 3
      push_word(32'h51); push_word(32'h52); push_word(32'h53);
      push_word(32'h54); push_word(32'h55);
      stop_after = 3;
      issue(4'b0111, 32'hA, 4'd5);
      chk("t4_abort_clr", 32'(master_abort), 32'd0);
      run_txn();
      chk("t4_cyc", 32'(cyc), 32'd6);
      chk("t4_tstop", 32'(target_stop), 32'd1);
      chk("t4_abort", 32'(master_abort), 32'd0);
      chk("t4_xfer", 32'(xfer_cnt), 32'd3);
      chk("t4_frame5", 32'(fr_hist[5]), 32'd1);
      chk("t4_irdy5", 32'(ir_hist[5]), 32'd0);
      chk("t4_memA", slv_mem[4'hA], 32'h51);
      chk("t4_memC", slv_mem[4'hC], 32'h53);
      stop_after = 0;
      @(posedge clk); #1;
      issue(4'b0111, 32'hA, 4'd1);
      chk("t4_flushed_err", 32'(req_err), 32'd1);
      chk("t4_flushed_busy", 32'(busy), 32'd0);

      // 5: reset in the middle of a read burst
      issue(4'b0110, 32'hA, 4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_busy_pre", 32'(busy), 32'd1);
      chk("t5_irdy_pre", 32'(irdy), 32'd0);
      reset = 1'b1;
      #1;
      chk("t5_frame", 32'(frame), 32'd1);
      chk("t5_irdy", 32'(irdy), 32'd1);
      chk("t5_ad_oe", 32'(dut.ad_oe), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      saw_done = 1'b0;
      repeat (2) begin @(posedge clk); #1; saw_done |= done; end
      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; saw_done |= done; end
      chk("t5_no_done", 32'(saw_done), 32'd0);
      issue(4'b0110, 32'hA, 4'd1);
      run_txn();
      chk("t5_cyc", 32'(cyc), 32'd2);
      chk("t5_nvalid", 32'(rd_q.size()), 32'd1);
      chk("t5_rd0", rd_q[0], 32'h51);
      chk("t5_xfer", 32'(xfer_cnt), 32'd1);
      @(posedge clk); #1;

      // 6: rejected requests, then an accepted single write
      push_word(32'h61);
      issue(4'b0111, 32'hA, 4'd2);
      chk("t6_short_err", 32'(req_err), 32'd1);
      chk("t6_short_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("t6_err_pulse", 32'(req_err), 32'd0);
      chk("t6_still_idle", 32'(busy), 32'd0);
      issue(4'b0010, 32'hA, 4'd1);
      chk("t6_badcmd_err", 32'(req_err), 32'd1);
      chk("t6_badcmd_busy", 32'(busy), 32'd0);
      issue(4'b0110, 32'hA, 4'd0);
      chk("t6_len0_err", 32'(req_err), 32'd1);
      issue(4'b0111, 32'hA, 4'd1);
      chk("t6_ok_err", 32'(req_err), 32'd0);
      run_txn();
      chk("t6_cyc", 32'(cyc), 32'd2);
      chk("t6_xfer", 32'(xfer_cnt), 32'd1);
      chk("t6_memA", slv_mem[4'hA], 32'h61);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
